// File: rtl/amx_mouse_rx_if.sv
// rtl/amx_mouse_rx_if.sv - AMX port pins and ps2_mouse packet bundle
interface amx_mouse_rx_if;
    logic [6:0]  din;
    logic        sel;
    logic [24:0] ps2_mouse;

    modport master (input din, output sel, output ps2_mouse);
    modport slave  (output din, input sel, input ps2_mouse);
endinterface

// File: rtl/amx_mouse_rx.sv
// rtl/amx_mouse_rx.sv - AMX joystick-port mouse reader producing ps2_mouse packets
module amx_mouse_rx #(
    parameter int POLL_DIV  = 4096,
    parameter int SEL_W     = 4,
    parameter int STEP      = 4,
    parameter int PKT_POLLS = 8
) (
    input  logic            clk_sys,
    input  logic            reset,
    amx_mouse_rx_if.master  bus
);
    localparam int PCW = $clog2(POLL_DIV);
    localparam int SCW = $clog2(SEL_W);
    localparam int PW  = $clog2(PKT_POLLS + 1);

    localparam logic [PCW-1:0] PC_RESET  = PCW'(POLL_DIV - 1);
    localparam logic [PCW-1:0] PC_RELOAD = PCW'(POLL_DIV - SEL_W - 3);
    localparam logic [SCW-1:0] SEL_LAST  = SCW'(SEL_W - 1);
    localparam logic [PW-1:0]  PKT_MAX   = PW'(PKT_POLLS);
    localparam logic signed [12:0] STEP_S = 13'(STEP);

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_SEL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic [1:0]        state;
    logic [PCW-1:0]    pcnt;
    logic [SCW-1:0]    scnt;
    logic [PW-1:0]     pollc;
    logic [6:0]        dsync1;
    logic [6:0]        dsync;
    logic [6:0]        smp;
    logic signed [11:0] accx;
    logic signed [11:0] accy;
    logic [2:0]        btn;
    logic [2:0]        last_btn;
    logic              sel_q;
    logic [24:0]       pkt;

    logic signed [11:0] accx_add;
    logic signed [11:0] accy_add;
    logic [8:0]         rep_x;
    logic [8:0]         rep_y;
    logic               emit;

    // Saturating add of one direction pulse; 00/11 codes leave the value alone.
    function automatic logic signed [11:0] step_sat(input logic signed [11:0] a,
                                                    input logic up, input logic dn);
        logic signed [12:0] s;
        logic signed [11:0] r;
        s = {a[11], a};
        if (up)
            s = s + STEP_S;
        else if (dn)
            s = s - STEP_S;
        if (s > 13'sd2047)
            r = 12'sd2047;
        else if (s < -13'sd2048)
            r = -12'sd2048;
        else
            r = s[11:0];
        return r;
    endfunction

    function automatic logic [8:0] clamp9(input logic signed [11:0] a);
        logic [8:0] r;
        if (a > 12'sd255)
            r = 9'h0FF;
        else if (a < -12'sd256)
            r = 9'h100;
        else
            r = a[8:0];
        return r;
    endfunction

    always_comb begin
        accx_add = step_sat(accx, smp[1:0] == 2'b01, smp[1:0] == 2'b10);
        accy_add = step_sat(accy, smp[3:2] == 2'b10, smp[3:2] == 2'b01);
        rep_x    = clamp9(accx);
        rep_y    = clamp9(accy);
        emit     = (pollc >= PKT_MAX) &&
                   ((accx != '0) || (accy != '0) || (btn != last_btn));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= S_WAIT;
            pcnt     <= PC_RESET;
            scnt     <= '0;
            pollc    <= '0;
            dsync1   <= '0;
            dsync    <= '0;
            smp      <= '0;
            accx     <= '0;
            accy     <= '0;
            btn      <= '0;
            last_btn <= '0;
            sel_q    <= 1'b0;
            pkt      <= '0;
        end else begin
            dsync1 <= bus.din;
            dsync  <= dsync1;
            case (state)
                S_WAIT: begin
                    if (pcnt == '0) begin
                        state <= S_SEL;
                        scnt  <= SEL_LAST;
                        sel_q <= 1'b1;
                    end else begin
                        pcnt <= pcnt - PCW'(1);
                    end
                end
                S_SEL: begin
                    if (scnt == '0) begin
                        smp   <= dsync;
                        sel_q <= 1'b0;
                        state <= S_ACC;
                    end else begin
                        scnt <= scnt - SCW'(1);
                    end
                end
                S_ACC: begin
                    accx <= accx_add;
                    accy <= accy_add;
                    btn  <= {smp[6], smp[4], smp[5]};
                    if (pollc != PKT_MAX)
                        pollc <= pollc + PW'(1);
                    state <= S_EMIT;
                end
                default: begin
                    // Reload accounts for the SEL, ACC and EMIT cycles so the poll period is exact.
                    if (emit) begin
                        pkt      <= {~pkt[24], rep_y[7:0], rep_x[7:0], 2'b00,
                                     rep_y[8], rep_x[8], 1'b1, btn};
                        pollc    <= '0;
                        accx     <= accx - $signed({{3{rep_x[8]}}, rep_x});
                        accy     <= accy - $signed({{3{rep_y[8]}}, rep_y});
                        last_btn <= btn;
                    end
                    pcnt  <= PC_RELOAD;
                    state <= S_WAIT;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.ps2_mouse = pkt;
endmodule

// File: tb/tb_amx_mouse_rx.sv
// tb/tb_amx_mouse_rx.sv - directed self-checking bench for amx_mouse_rx
module tb_amx_mouse_rx;
    localparam int P  = 16;
    localparam int SW = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int n_checks = 0;
    int n_pass   = 0;

    amx_mouse_rx_if bus ();
    amx_mouse_rx_if bus2 ();

    amx_mouse_rx #(.POLL_DIV(P), .SEL_W(SW), .STEP(4), .PKT_POLLS(8)) dut (
        .clk_sys(clk), .reset(rst), .bus(bus));

    amx_mouse_rx #(.POLL_DIV(P), .SEL_W(SW), .STEP(4), .PKT_POLLS(1000)) dut2 (
        .clk_sys(clk), .reset(rst2), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic sel_of(input int which);
        return (which == 0) ? bus.sel : bus2.sel;
    endfunction

    // Returns at the negedge right after the EMIT cycle of the next poll.
    task automatic wait_poll(input int which);
        int t;
        t = 0;
        while (sel_of(which) !== 1'b1 && t < 3 * P) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (sel_of(which) !== 1'b0 && t < 3 * P) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3 * P) begin
            n_checks++;
            $error("FAIL poll_timeout: observed sel stuck expected a poll (dut %0d)", which);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at the negedge where reset was released.
    task automatic check_first_poll(input string tag);
        int bad_sel;
        int bad_pkt;
        bad_sel = 0;
        bad_pkt = 0;
        for (int k = 1; k <= P + SW; k++) begin
            @(negedge clk);
            if (bus.sel !== ((k >= P && k < P + SW) ? 1'b1 : 1'b0)) bad_sel++;
            if (bus.ps2_mouse !== 25'h0) bad_pkt++;
        end
        check({tag, "_sel_timing"}, bad_sel, 0);
        check({tag, "_pkt_zero"}, bad_pkt, 0);
    endtask

    initial begin
        bus.din  = 7'b0;
        bus2.din = 7'b0;

        // Reset state and first poll timing
        do_reset();
        check("reset_sel", {31'b0, bus.sel}, 0);
        check("reset_pkt", bus.ps2_mouse, 0);
        check("reset_accx", {20'b0, dut.accx}, 0);
        check_first_poll("reset");

        // Single +X for 8 polls
        bus.din = 7'b0;
        do_reset();
        bus.din = 7'b0000001;
        for (int n = 1; n <= 8; n++) begin
            wait_poll(0);
            if (n == 7) check("plusx_no_pkt", bus.ps2_mouse, 0);
        end
        check("plusx_pkt", bus.ps2_mouse, 25'h1002008);
        check("plusx_accx", {20'b0, dut.accx}, 0);

        // Y negative, 70 polls
        bus.din = 7'b0;
        do_reset();
        bus.din = 7'b0000100;
        for (int n = 1; n <= 70; n++) begin
            int k;
            wait_poll(0);
            k = n / 8;
            check($sformatf("negy_poll%0d", n), bus.ps2_mouse,
                  (k == 0) ? 32'h0 : (32'h0E00028 | (32'(k % 2) << 24)));
            if (n == 64) check("negy_accy_zero", {20'b0, dut.accy}, 0);
        end
        check("negy_accy_rem", {20'b0, dut.accy}, 32'hFE8);

        // Button only (left)
        bus.din = 7'b0;
        do_reset();
        bus.din = 7'b0100000;
        for (int n = 1; n <= 20; n++) begin
            wait_poll(0);
            if (n == 7) check("btn_no_pkt", bus.ps2_mouse, 0);
            if (n == 8) check("btn_pkt", bus.ps2_mouse, 25'h1000009);
        end
        check("btn_static", bus.ps2_mouse, 25'h1000009);

        // Reset on the 2nd SEL cycle
        begin
            int t;
            t = 0;
            while (bus.sel !== 1'b1 && t < 3 * P) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            check("midsel_sel_high", {31'b0, bus.sel}, 1);
            rst = 1'b1;
            @(negedge clk);
            check("midsel_sel_low", {31'b0, bus.sel}, 0);
            check("midsel_pkt_zero", bus.ps2_mouse, 0);
            rst = 1'b0;
            check_first_poll("midsel");
        end

        // Clamp and saturation on the PKT_POLLS=1000 instance
        @(negedge clk);
        rst2 = 1'b0;
        bus2.din = 7'b0000001;
        for (int n = 1; n <= 600; n++) begin
            wait_poll(1);
            if (n == 511) check("sat_accx_511", {20'b0, dut2.accx}, 32'h7FC);
            if (n == 512) check("sat_accx_512", {20'b0, dut2.accx}, 32'h7FF);
        end
        check("sat_accx_600", {20'b0, dut2.accx}, 32'h7FF);
        check("sat_no_pkt", bus2.ps2_mouse, 0);
        bus2.din = 7'b0;
        for (int n = 601; n <= 2000; n++) begin
            wait_poll(1);
            if (n == 999) check("clamp_no_pkt", bus2.ps2_mouse, 0);
            if (n == 1000) begin
                check("clamp_pkt1", bus2.ps2_mouse, 25'h100FF08);
                check("clamp_accx1", {20'b0, dut2.accx}, 32'h700);
            end
            if (n == 1999) check("clamp_hold", bus2.ps2_mouse, 25'h100FF08);
        end
        check("clamp_pkt2", bus2.ps2_mouse, 25'h000FF08);
        check("clamp_accx2", {20'b0, dut2.accx}, 32'h601);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/amx_mouse_rx.md
# amx_mouse_rx

Reads an AMX-style joystick-port mouse and converts its pulses into the 25-bit `ps2_mouse` packet format used elsewhere in the core. It is the host/reader end of the AMX interface and sits between the SNAC/user-port input pins and any consumer of `ps2_mouse`. Each poll strobes `sel`, samples the 7-bit port, and folds the direction pulses into signed X/Y accumulators. Packets are emitted with a toggling strobe bit.

## Interface
- `POLL_DIV`, 4096: clocks from one poll start to the next; ≥ SEL_W+4.
- `SEL_W`, 4: cycles `sel` is held high per poll; ≥ 3, to cover the 2-flop input synchroniser.
- `STEP`, 4: counts added per direction pulse.
- `PKT_POLLS`, 8: minimum polls between emitted packets.
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  7  AMX port, asynchronous:
  - [6] middle button, [5] left button, [4] right button.
  - [1:0] X: 01 = +X, 10 = −X.
  - [3:2] Y: 10 = +Y, 01 = −Y.
  - 00 and 11 on either pair mean no motion.
- `sel`  out  1  poll strobe. Its falling edge clears the device's latched pulses.
- `ps2_mouse`  out  25  packet:
  - [2:0] {middle, right, left}.
  - [3] = 1.
  - [4] X sign, [5] Y sign.
  - [7:6] = 0.
  - [15:8] X low byte, [23:16] Y low byte.
  - [24] strobe; toggles once per new packet.

## Operation
- `din` passes through a 2-flop synchroniser (`dsync`) before any use.
- FSM states: WAIT, SEL, ACC, EMIT.
  - WAIT: `pcnt` counts down. At 0, go to SEL; `scnt` = SEL_W−1 and `sel` = 1 from the next cycle.
  - SEL: `sel` = 1 and `scnt` counts down. At `scnt` = 0, capture `dsync` into `smp` and go to ACC. `sel` drops to 0 on the ACC cycle.
  - ACC, one cycle:
    - `accx += ±STEP` per `smp[1:0]`; `accy += ±STEP` per `smp[3:2]`.
    - `btn` = {smp[6], smp[4], smp[5]}.
    - `pollc` increments, saturating at PKT_POLLS.
    - Go to EMIT.
  - EMIT, one cycle:
    - Emit if `pollc` ≥ PKT_POLLS and (`accx` ≠ 0, `accy` ≠ 0, or `btn` ≠ last sent buttons).
    - On emit: `ps2_mouse[23:0]` is loaded, [24] toggles, `pollc` = 0, and accumulators are reduced by the reported amount.
    - Return to WAIT with `pcnt` = POLL_DIV−SEL_W−3, so the poll period is exactly POLL_DIV.
- Accumulators are 12-bit signed. Addition saturates at +2047/−2048 and never wraps.
- Reported value is the accumulator clamped to [−256, +255], as 9-bit two's complement: sign in bit 4/5, low byte in [15:8]/[23:16].
  - Example: `accx` = −300 reports −256 (sign 1, byte 0x00) and leaves `accx` = −44.
  - Example: `accx` = +300 reports 255 and leaves +45.
- A button-only change emits a packet with a zero report and accumulators unchanged.

## Timing
- Reset values:
  - `sel` = 0, `ps2_mouse` = 0 (strobe = 0), accumulators = 0.
  - `pollc` = 0, last sent buttons = 0, state WAIT, `pcnt` = POLL_DIV−1.
- First `sel` rise is POLL_DIV cycles after reset deasserts. Each high pulse lasts exactly SEL_W cycles.
- Capture latency: `smp` reflects `din` as it was ≥ 2 cycles before the last SEL cycle.
- Packet latency: `ps2_mouse` updates 2 cycles after `sel` falls (ACC, then EMIT register).
- Packet rate: at most one packet per PKT_POLLS polls, no matter how much motion accumulates.
- Reset mid-poll: `sel` = 0 on the next cycle, and the partial sample is discarded.
- `din` = 11 on a pair is treated as no motion; buttons are still sampled.
- Saturated accumulator plus further pulses in the same direction stays at the limit.

## Test plan
- Reset check: hold reset 5 cycles, release.
  - `sel` = 0 and `ps2_mouse` = 0 for POLL_DIV−1 cycles.
  - `sel` high exactly SEL_W cycles starting at cycle POLL_DIV.
- Single +X: `din` = 0000001 for 8 polls.
  - One packet: [15:8] = 0x20, bit4 = 0, bit3 = 1, strobe toggles once.
- Y negative, 70 polls of `din` = 0000100:
  - Packets report −32 each (`0xE0`, bit5 = 1).
  - After the final emit, `accy` = 0.
  - No packet while `pollc` < 8.
- Button only: `din` = 0100000 (left).
  - Packet after the 8th poll with [2:0] = 001, bytes 0, strobe toggled.
  - No further packets while the input stays static.
- Clamp and saturation:
  - Drive +X pulses for 600 polls with PKT_POLLS set to 1000.
  - `accx` saturates at 2047.
  - The first emitted packets report 255 and decrement by 255 each.
- Reset mid-SEL:
  - Assert reset on the 2nd SEL cycle: `sel` = 0 next cycle and `ps2_mouse` = 0.
  - The next poll starts POLL_DIV cycles after release.
